// File: rtl/shift_arbiter_seq.sv
// Two-requester round-robin arbiter feeding a multi-cycle barrel shifter.
// Each operation shifts at most STEP bit positions per cycle until the full amount has been applied.
module shift_arbiter_seq #(
  parameter int unsigned STEP = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_data,
  input  logic [1:0]  req0_shift,
  input  logic [4:0]  req0_amt,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_data,
  input  logic [1:0]  req1_shift,
  input  logic [4:0]  req1_amt,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        res_id,
  output logic        busy
);

  localparam logic [4:0] StepW = 5'(STEP);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e      state_q, state_d;
  logic [31:0] data_q, data_d;
  logic [1:0]  op_q, op_d;
  logic [4:0]  rem_q, rem_d;
  logic        res_id_q, res_id_d;
  logic        last_grant_q, last_grant_d;

  logic        grant1;
  logic        accept;
  logic [4:0]  k;
  logic [31:0] step_val;

  // On a tie, the requester that was not granted last wins.
  always_comb begin
    grant1     = req1_valid & (~req0_valid | ~last_grant_q);
    req0_ready = (state_q == StIdle) & ~rst & req0_valid & ~grant1;
    req1_ready = (state_q == StIdle) & ~rst & grant1;
    accept     = req0_ready | req1_ready;
  end

  always_comb begin
    k = (rem_q < StepW) ? rem_q : StepW;
    unique case (op_q)
      2'b00: step_val = data_q << k;
      2'b01: step_val = data_q >> k;
      2'b10: step_val = $unsigned($signed(data_q) >>> k);
      2'b11: step_val = (data_q >> k) | (data_q << (6'd32 - {1'b0, k}));
    endcase
  end

  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    op_d         = op_q;
    rem_d        = rem_q;
    res_id_d     = res_id_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          data_d       = grant1 ? req1_data : req0_data;
          op_d         = grant1 ? req1_shift : req0_shift;
          rem_d        = grant1 ? req1_amt : req0_amt;
          res_id_d     = grant1;
          last_grant_d = grant1;
          state_d      = (rem_d == 5'd0) ? StDone : StShift;
        end
      end
      StShift: begin
        data_d = step_val;
        rem_d  = rem_q - k;
        if (rem_q == k) state_d = StDone;
      end
      StDone: begin
        if (res_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      data_q       <= '0;
      op_q         <= '0;
      rem_q        <= '0;
      res_id_q     <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      op_q         <= op_d;
      rem_q        <= rem_d;
      res_id_q     <= res_id_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign res_valid = (state_q == StDone);
  assign res_data  = data_q;
  assign res_id    = res_id_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: doc/shift_arbiter_seq.md
SHIFT_ARBITER_SEQ -- requirements
Module: shift_arbiter_seq

Interface
REQ-001 Parameter STEP, default 4, meaning maximum bit positions shifted per cycle; legal values 1, 2, 4, 8, 16.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 req0_data  input  32  requester 0 operand.
REQ-007 req0_shift  input  2  requester 0 op: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
REQ-008 req0_amt  input  5  requester 0 shift amount, 0..31.
REQ-009 req1_valid, req1_ready, req1_data, req1_shift, req1_amt: same directions, widths and meanings for requester 1.
REQ-010 res_valid  output  1  result available.
REQ-011 res_ready  input  1  consumer accepts result.
REQ-012 res_data  output  32  shifted result.
REQ-013 res_id  output  1  requester index owning res_data.
REQ-014 busy  output  1  high whenever state is not IDLE.

Function
REQ-015 FSM SHALL have states IDLE, SHIFT, DONE.
REQ-016 In IDLE, grant SHALL go to the single valid requester; with both valid, to the requester not granted last (round-robin via last_grant register).
REQ-017 reqN_ready SHALL be combinational, high only in IDLE for the granted requester; at most one ready high per cycle; accept = valid & ready.
REQ-018 On accept: capture operand, op, amount into working registers, res_id <= granted index, last_grant <= granted index.
REQ-019 On accept with amt = 0: next state DONE, result equals operand unchanged for every op (no RRX on ROR #0).
REQ-020 On accept with amt > 0: next state SHIFT, remaining <= amt.
REQ-021 In SHIFT, each cycle apply k = min(remaining, STEP) positions of the captured op to the working value; remaining <= remaining - k; when remaining - k = 0, next state DONE.
REQ-022 Per-step semantics: LSL zero-fills low bits; LSR zero-fills high bits; ASR replicates bit 31; ROR rotates right (bits leaving bit 0 enter bit 31).
REQ-023 Composite result SHALL equal a single one-shot shift of the operand by amt (ROR mod 32).
REQ-024 Latency: SHIFT occupies exactly ceil(amt/STEP) cycles; res_valid rises the cycle after the last SHIFT cycle (cycle after accept when amt = 0).
REQ-025 In DONE, res_valid = 1; res_data and res_id SHALL hold stable until res_ready = 1; on that edge, next state IDLE.
REQ-026 No accept SHALL occur in the cycle of a result handshake; minimum one IDLE cycle between operations.
REQ-027 Deasserting reqN_valid before ready SHALL have no effect on state or last_grant.
REQ-028 Request inputs SHALL be ignored outside IDLE.

Reset
REQ-029 On rst = 1 at a clock edge: state IDLE, res_valid 0, res_data 0, res_id 0, remaining 0, last_grant 1 (requester 0 wins first tie), busy 0.
REQ-030 rst during SHIFT or DONE SHALL abort the operation; no result emitted; rst overrides all other inputs in the same cycle.
REQ-031 reqN_ready SHALL be 0 while rst = 1.

Verification
REQ-032 Reset, then req0 LSL data 0x0000_0001 amt 31, res_ready=1, STEP=4 -> req0_ready 1 cycle, 8 SHIFT cycles, res_data 0x8000_0000, res_id 0.
REQ-033 Both valid from reset, continuous: req0 ASR 0x8000_0000 amt 4, req1 LSR 0x8000_0000 amt 4 -> first result 0xF800_0000 id 0, second 0x0800_0000 id 1, grants alternate 0,1,0,1.
REQ-034 req1 ROR 0x0000_00F1 amt 4 -> res_data 0x1000_000F; ROR amt 0 on 0x1234_5678 -> 0x1234_5678 one cycle after accept.
REQ-035 res_ready held 0 for 5 cycles in DONE -> res_valid, res_data, res_id stable; no reqN_ready; IDLE after release.
REQ-036 rst asserted in 3rd SHIFT cycle of amt 20 -> next cycle IDLE, res_valid 0, busy 0; following req0 tie-break winner is req0.
